// File: rtl/spi_agent_if.sv
// spi_agent_if: pin-level SPI lines plus the byte-level parent handshake of spi_agent.
// Optional macro SPI_AGENT_MISO_OE_EN adds the miso_oe output enable.
interface spi_agent_if;
  logic       cpol;
  logic       cpha;
  logic       cs_n;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
`ifdef SPI_AGENT_MISO_OE_EN
  logic       miso_oe;

  modport slave (
    input  cpol, cpha, cs_n, sck, mosi, tx_data, tx_load,
    output miso, tx_ready, rx_data, rx_valid, busy, miso_oe
  );
  modport master (
    output cpol, cpha, cs_n, sck, mosi, tx_data, tx_load,
    input  miso, tx_ready, rx_data, rx_valid, busy, miso_oe
  );
`else
  modport slave (
    input  cpol, cpha, cs_n, sck, mosi, tx_data, tx_load,
    output miso, tx_ready, rx_data, rx_valid, busy
  );
  modport master (
    output cpol, cpha, cs_n, sck, mosi, tx_data, tx_load,
    input  miso, tx_ready, rx_data, rx_valid, busy
  );
`endif
endinterface

// File: rtl/spi_agent.sv
// spi_agent: SPI target that oversamples cs_n/sck/mosi in the clk domain, moves one
// byte each way per 8 sck cycles in any cpol/cpha mode, and talks to its parent through
// a one-deep tx buffer and a one-cycle rx strobe.
// Optional macro SPI_AGENT_MISO_OE_EN adds miso_oe (= busy) and forces miso low while
// it is deasserted so the pin can be shared through a tristate at the top level.
module spi_agent (
  input  logic        clk,
  input  logic        rst_n,
  spi_agent_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic       r_cs_s1, r_cs_s2, r_cs_s3;
  logic       r_sck_s1, r_sck_s2, r_sck_s3;
  logic       r_mosi_s1, r_mosi_s2;

  logic       r_cpol, r_cpha;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx_shift;
  logic [7:0] r_tx_shift;
  logic [7:0] r_tx_buf;
  logic       r_tx_full;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_miso;

  logic       w_cpol_nxt, w_cpha_nxt;
  logic [2:0] w_bit_cnt_nxt;
  logic [7:0] w_rx_shift_nxt;
  logic [7:0] w_tx_shift_nxt;
  logic [7:0] w_tx_buf_nxt;
  logic       w_tx_full_nxt;
  logic [7:0] w_rx_data_nxt;
  logic       w_rx_valid_nxt;
  logic       w_miso_nxt;
  logic       w_consume;
  logic       w_lead, w_trail, w_sample, w_shift;
  logic       w_cs_fall, w_cs_rise;

  assign w_cs_fall = ~r_cs_s2 &  r_cs_s3;
  assign w_cs_rise =  r_cs_s2 & ~r_cs_s3;

  // Bring the asynchronous SPI pins into the clk domain; s3 taps give edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_s3   <= 1'b1;
      r_sck_s1  <= 1'b0;
      r_sck_s2  <= 1'b0;
      r_sck_s3  <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_cs_s1   <= bus.cs_n;
      r_cs_s2   <= r_cs_s1;
      r_cs_s3   <= r_cs_s2;
      r_sck_s1  <= bus.sck;
      r_sck_s2  <= r_sck_s1;
      r_sck_s3  <= r_sck_s2;
      r_mosi_s1 <= bus.mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  // State register and all datapath registers, loaded from the next-value logic below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= 8'h00;
      r_tx_shift <= 8'hFF;
      r_tx_buf   <= 8'h00;
      r_tx_full  <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_miso     <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_cpol     <= w_cpol_nxt;
      r_cpha     <= w_cpha_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_buf   <= w_tx_buf_nxt;
      r_tx_full  <= w_tx_full_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_miso     <= w_miso_nxt;
    end
  end

  // Next-state and datapath: frame start/stop on cs_n edges, sample/shift on sck edges.
  always_comb begin
    w_state_nxt    = r_state;
    w_cpol_nxt     = r_cpol;
    w_cpha_nxt     = r_cpha;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_rx_shift_nxt = r_rx_shift;
    w_tx_shift_nxt = r_tx_shift;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_consume      = 1'b0;
    w_lead         = (r_sck_s2 != r_sck_s3) && (r_sck_s3 == r_cpol);
    w_trail        = (r_sck_s2 != r_sck_s3) && (r_sck_s2 == r_cpol);
    w_sample       = r_cpha ? w_trail : w_lead;
    w_shift        = r_cpha ? w_lead  : w_trail;

    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt    = ST_ACTIVE;
          w_cpol_nxt     = bus.cpol;
          w_cpha_nxt     = bus.cpha;
          w_bit_cnt_nxt  = 3'd0;
          w_rx_shift_nxt = 8'h00;
          w_tx_shift_nxt = r_tx_full ? r_tx_buf : 8'hFF;
          w_consume      = 1'b1;
        end else begin
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (w_cs_rise) begin
          // Frame aborted or finished: drop any partial byte.
          w_state_nxt    = ST_IDLE;
          w_bit_cnt_nxt  = 3'd0;
          w_rx_shift_nxt = 8'h00;
        end else if (w_sample) begin
          w_rx_shift_nxt = {r_rx_shift[6:0], r_mosi_s2};
          w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_rx_data_nxt  = {r_rx_shift[6:0], r_mosi_s2};
            w_rx_valid_nxt = 1'b1;
            w_tx_shift_nxt = r_tx_full ? r_tx_buf : 8'hFF;
            w_consume      = 1'b1;
          end else begin
            w_rx_valid_nxt = 1'b0;
          end
        end else if (w_shift) begin
          // At bit_cnt 0 the freshly loaded MSB must stay on the line.
          if (r_bit_cnt != 3'd0) begin
            w_tx_shift_nxt = {r_tx_shift[6:0], 1'b1};
          end else begin
            w_tx_shift_nxt = r_tx_shift;
          end
        end else begin
          w_state_nxt    = ST_ACTIVE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // A consume frees the slot in the same cycle, so a simultaneous load is accepted.
    if (bus.tx_load && (!r_tx_full || w_consume)) begin
      w_tx_buf_nxt  = bus.tx_data;
      w_tx_full_nxt = 1'b1;
    end else begin
      w_tx_buf_nxt  = r_tx_buf;
      w_tx_full_nxt = w_consume ? 1'b0 : r_tx_full;
    end

    if (w_state_nxt == ST_ACTIVE) begin
      w_miso_nxt = w_tx_shift_nxt[7];
    end else begin
      w_miso_nxt = 1'b1;
    end
  end

  assign bus.tx_ready = ~r_tx_full;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.busy     = ~r_cs_s2;
`ifdef SPI_AGENT_MISO_OE_EN
  assign bus.miso_oe  = ~r_cs_s2;
  assign bus.miso     = (~r_cs_s2) ? r_miso : 1'b0;
`else
  assign bus.miso     = r_miso;
`endif

endmodule

// File: tb/tb_spi_agent.sv
// tb_spi_agent: SPI host model driving spi_agent, checked against a byte-level
// reference of the one-deep tx buffer and the expected rx byte stream.
module tb_spi_agent;

  logic clk;
  logic rst_n;

  spi_agent_if bus ();

  spi_agent dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam int H = 5;  // sck half period in clk cycles (sck = clk/10)

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rx_seen[$];
  logic [7:0] rx_exp[$];
  bit         mdl_full;
  logic [7:0] mdl_buf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collect every rx_valid strobe away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.rx_valid === 1'b1) rx_seen.push_back(bus.rx_data);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference buffer: a byte is taken at frame start and at every completed byte.
  task automatic mdl_take(output logic [7:0] v);
    v = mdl_full ? mdl_buf : 8'hFF;
    mdl_full = 1'b0;
  endtask

  task automatic load(input logic [7:0] v);
    bus.tx_data = v;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
    if (!mdl_full) begin
      mdl_full = 1'b1;
      mdl_buf  = v;
    end
  endtask

  task automatic half(input bit do_load, input logic [7:0] v);
    if (do_load) begin
      load(v);
      clks(H - 1);
    end else begin
      clks(H);
    end
  endtask

  task automatic cs_begin(input logic pol, input logic pha, output logic [7:0] first);
    bus.cpol = pol;
    bus.cpha = pha;
    bus.sck  = pol;
    clks(4);
    bus.cs_n = 1'b0;
    mdl_take(first);
    clks(4);
  endtask

  task automatic cs_end();
    clks(5);
    bus.cs_n = 1'b1;
    clks(6);
  endtask

  // Host side of one byte (or its first nbits bits), MSB first.
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit do_load,
                      input int load_bit, input logic [7:0] load_val, output logic [7:0] mi);
    int i;
    mi = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      i = 7 - k;
      if (!bus.cpha) bus.mosi = mo[i];
      half(do_load && (load_bit == i), load_val);
      if (!bus.cpha) mi[i] = bus.miso;
      else           bus.mosi = mo[i];
      bus.sck = ~bus.cpol;
      half(1'b0, 8'h00);
      if (bus.cpha) mi[i] = bus.miso;
      bus.sck = bus.cpol;
    end
  endtask

  task automatic rx_compare(input string tag);
    check_eq({tag, "_rx_count"}, rx_seen.size(), rx_exp.size());
    for (int i = 0; i < rx_exp.size() && i < rx_seen.size(); i++)
      check_eq($sformatf("%s_rx%0d", tag, i), rx_seen[i], rx_exp[i]);
    rx_seen.delete();
    rx_exp.delete();
  endtask

  initial begin
    logic [7:0] e, mi, nx, lv;
    logic [7:0] mos[3];
    logic [7:0] ex[3];
    logic [1:0] md;
    int nb, lb;
    bit dl;

    rst_n = 1'b0;
    bus.cpol = 1'b0; bus.cpha = 1'b0; bus.cs_n = 1'b1; bus.sck = 1'b0; bus.mosi = 1'b0;
    bus.tx_data = 8'h00; bus.tx_load = 1'b0;
    mdl_full = 1'b0; mdl_buf = 8'h00;
    clks(3);
    check_eq("rst_miso", bus.miso, 1'b1);
    check_eq("rst_tx_ready", bus.tx_ready, 1'b1);
    check_eq("rst_rx_valid", bus.rx_valid, 1'b0);
    check_eq("rst_rx_data", bus.rx_data, 8'h00);
    check_eq("rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    clks(3);

    // Mode 0, preloaded 0xA5, host sends 0x3C.
    load(8'hA5);
    check_eq("m0_ready_loaded", bus.tx_ready, 1'b0);
    cs_begin(1'b0, 1'b0, e);
    check_eq("m0_busy", bus.busy, 1'b1);
    check_eq("m0_ready_csfall", bus.tx_ready, 1'b1);
    xfer(8'h3C, 8, 1'b0, 0, 8'h00, mi);
    mdl_take(nx);
    check_eq("m0_host_rx", mi, 8'hA5);
    rx_exp.push_back(8'h3C);
    cs_end();
    rx_compare("m0");
    check_eq("m0_idle_busy", bus.busy, 1'b0);
    check_eq("m0_idle_miso", bus.miso, 1'b1);

    // Modes 1..3: two-byte burst, second byte loaded mid-byte.
    for (int m = 1; m < 4; m++) begin
      md = m[1:0];
      load(8'h81);
      cs_begin(md[1], md[0], e);
      xfer(8'h12, 8, 1'b1, 4, 8'h7E, mi);
      mdl_take(nx);
      check_eq($sformatf("burst_m%0d_b0", m), mi, 8'h81);
      xfer(8'h34, 8, 1'b0, 0, 8'h00, mi);
      mdl_take(nx);
      check_eq($sformatf("burst_m%0d_b1", m), mi, 8'h7E);
      rx_exp.push_back(8'h12);
      rx_exp.push_back(8'h34);
      cs_end();
      rx_compare($sformatf("burst_m%0d", m));
    end

    // Empty tx buffer sends 0xFF.
    cs_begin(1'b0, 1'b0, e);
    xfer(8'h55, 8, 1'b0, 0, 8'h00, mi);
    mdl_take(nx);
    check_eq("empty_host_rx", mi, 8'hFF);
    rx_exp.push_back(8'h55);
    cs_end();
    rx_compare("empty");

    // Abort after 5 sck cycles; the byte already in the shift register is lost.
    load(8'h5A);
    cs_begin(1'b0, 1'b1, e);
    xfer(8'hF0, 5, 1'b0, 0, 8'h00, mi);
    cs_end();
    rx_compare("abort");
    cs_begin(1'b0, 1'b1, e);
    xfer(8'h96, 8, 1'b0, 0, 8'h00, mi);
    mdl_take(nx);
    check_eq("after_abort_host_rx", mi, 8'hFF);
    rx_exp.push_back(8'h96);
    cs_end();
    rx_compare("after_abort");

    // tx_load while the buffer is full is ignored.
    load(8'h33);
    load(8'hEE);
    check_eq("ignored_ready", bus.tx_ready, 1'b0);
    cs_begin(1'b1, 1'b0, e);
    xfer(8'hC3, 8, 1'b0, 0, 8'h00, mi);
    mdl_take(nx);
    check_eq("ignored_host_rx", mi, 8'h33);
    rx_exp.push_back(8'hC3);
    cs_end();
    rx_compare("ignored");

    // Randomized bursts in random modes against the reference buffer.
    for (int it = 0; it < 10; it++) begin
      md = 2'($urandom_range(3, 0));
      nb = $urandom_range(3, 1);
      if ($urandom_range(1, 0) == 1) load(8'($urandom_range(255, 0)));
      cs_begin(md[1], md[0], ex[0]);
      for (int b = 0; b < nb; b++) begin
        mos[b] = 8'($urandom_range(255, 0));
        dl     = ($urandom_range(1, 0) == 1);
        lb     = $urandom_range(6, 0);
        lv     = 8'($urandom_range(255, 0));
        xfer(mos[b], 8, dl, lb, lv, mi);
        mdl_take(nx);
        if (b < 2) ex[b + 1] = nx;
        check_eq($sformatf("rnd%0d_b%0d_host_rx", it, b), mi, ex[b]);
        rx_exp.push_back(mos[b]);
      end
      cs_end();
      rx_compare($sformatf("rnd%0d", it));
      check_eq($sformatf("rnd%0d_ready", it), bus.tx_ready, !mdl_full);
    end

    // Reset asserted mid-byte.
    load(8'h42);
    cs_begin(1'b1, 1'b1, e);
    xfer(8'hAA, 3, 1'b0, 0, 8'h00, mi);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_miso", bus.miso, 1'b1);
    check_eq("midrst_tx_ready", bus.tx_ready, 1'b1);
    check_eq("midrst_rx_valid", bus.rx_valid, 1'b0);
    check_eq("midrst_rx_data", bus.rx_data, 8'h00);
    check_eq("midrst_busy", bus.busy, 1'b0);
    mdl_full = 1'b0;
    rx_seen.delete();
    rx_exp.delete();
    bus.cs_n = 1'b1;
    bus.sck  = 1'b0;
    clks(3);
    rst_n = 1'b1;
    clks(3);
    check_eq("postrst_tx_ready", bus.tx_ready, 1'b1);
    check_eq("postrst_busy", bus.busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_agent.md
# spi_agent

SPI agent (slave) that answers the team's SPI host over cs_n/sck/mosi/miso, oversampling all SPI pins in the system clock domain. It moves one byte in each direction per 8 sck cycles, supports all four cpol/cpha modes, and hands bytes to a parent FSM through a one-deep transmit buffer and a one-cycle receive strobe. It is the peer of the host block and is used in loopback benches and in FPGA designs that act as an SPI target.

## Interface
- No parameters.
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpol  in  1  sck idle level; captured at cs_n assertion
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge; captured at cs_n assertion
- cs_n  in  1  chip select from host, active low, asynchronous to clk
- sck  in  1  SPI clock from host, asynchronous to clk
- mosi  in  1  host-to-agent data, MSB first
- miso  out  1  agent-to-host data, MSB first
- tx_data  in  8  next byte to send
- tx_load  in  1  write tx_data into tx buffer; honoured only while tx_ready=1
- tx_ready  out  1  tx buffer empty
- rx_data  out  8  last complete received byte; held until the next byte completes
- rx_valid  out  1  one-cycle strobe: rx_data updated
- busy  out  1  synchronised cs_n is low

## Operation
- Synchronisers: cs_n, sck and mosi each pass through 2 flops (s1, s2). sck and cs_n also have a third flop (s3) for edge detection. Reset values: cs_n chain 1; sck chain 0; mosi chain 0.
- States:
  - IDLE: synced cs_n high.
  - ACTIVE: synced cs_n low.
- IDLE->ACTIVE on the synced cs_n falling edge:
  - latch cpol/cpha;
  - bit_cnt=0;
  - load tx shift register from the tx buffer, or 0xFF if the buffer is empty;
  - set tx_ready=1.
- Leading edge: synced sck leaves the latched cpol level. Trailing edge: synced sck returns to it. With cpha=0 the sample edge is leading and the shift edge is trailing; cpha=1 swaps them.
- Sample edge:
  - rx_shift = {rx_shift[6:0], mosi_s2};
  - bit_cnt = bit_cnt+1, 3-bit, wraps 7->0.
  - On the 8th sample: rx_data = completed byte; rx_valid=1 for one cycle; tx shift register reloads from the tx buffer (0xFF if empty) and the buffer is marked empty.
- Shift edge: tx shift register shifts left by one, 1 fills LSB, only if bit_cnt!=0. When bit_cnt==0 it holds, so the freshly loaded MSB stays on the line.
- miso = tx_shift[7] in ACTIVE; 1 in IDLE.
- Any->IDLE on the synced cs_n rising edge:
  - bit_cnt=0; partial rx bits discarded; no rx_valid.
  - A byte already moved into the shift register is lost.
  - The tx buffer keeps its contents if it was not consumed.
- tx_load while tx_ready=0 is ignored. A tx_load in the same cycle as a buffer consume is accepted: the consume takes the old content and the new byte stays buffered.
- sck edges while synced cs_n is high are ignored.

## Timing
- Reset values: miso=1, tx_ready=1, rx_valid=0, rx_data=0x00, busy=0, bit_cnt=0, tx buffer empty.
- A pin transition is captured on clk edge 1 and acted on at clk edge 3:
  - rx_valid rises 3 clk edges after the 8th sample edge at the pin;
  - miso changes 3 clk edges after a shift edge at the pin;
  - busy follows cs_n with 2 clk edges of latency.
- Constraints on the host:
  - sck high and low times ≥ 4 clk periods;
  - cs_n falling to first sck edge ≥ 4 clk periods;
  - last sck edge to cs_n rising ≥ 4 clk periods.
- Back-to-back bytes without cs_n deassertion are supported. tx_load must occur before the 8th sample edge of the current byte for the new byte to go out next.

## Configuration
- SPI_AGENT_MISO_OE_EN defined: adds output miso_oe (1 bit, reset 0) = busy. miso is driven 0 when miso_oe=0, so a top-level tristate buffer can share the line.
- Not defined: no miso_oe port; miso idles at 1 as described above.

## Test plan
- Mode 0, cpol=0/cpha=0, sck = clk/10: tx_data=0xA5 preloaded, host sends 0x3C -> host receives 0xA5; rx_data=0x3C with a single rx_valid pulse; tx_ready=1 after cs_n falls.
- Modes 1–3, 2-byte burst without cs_n release, tx 0x81 then 0x7E (second loaded mid-byte), host sends 0x12,0x34 -> host receives 0x81,0x7E; two rx_valid pulses, 0x12 then 0x34.
- Empty tx buffer, host sends 0x55 -> host receives 0xFF; rx_data=0x55.
- cs_n raised after 5 sck cycles, then a new full transfer of 0x96 -> no rx_valid for the aborted byte; the next byte is 0x96; bit_cnt restarts at 0.
- rst_n asserted mid-byte -> all outputs at reset values immediately; tx_ready=1 and busy=0 after release.
- tx_load while tx_ready=0 with 0xEE -> ignored; the originally buffered byte is transmitted.
